// File: rtl/fft_bf_sequencer_if.sv
// Sequencer bus: host start/done plus the memory, twiddle and butterfly control lines.
// Optional macro FFT_IFFT_EN adds the i_inverse request bit.
interface fft_bf_sequencer_if #(parameter int LOG2N = 3);
   logic             i_start;
`ifdef FFT_IFFT_EN
   logic             i_inverse;
`endif
   logic             o_busy;
   logic             o_done;
   logic [LOG2N-1:0] o_stage;
   logic             o_rd_en;
   logic [LOG2N-1:0] o_rd_addr_a;
   logic [LOG2N-1:0] o_rd_addr_b;
   logic [LOG2N-2:0] o_tw_addr;
   logic             o_wr_en;
   logic [LOG2N-1:0] o_wr_addr_a;
   logic [LOG2N-1:0] o_wr_addr_b;
   logic             o_tw_conj;

   modport master (
      input  i_start,
`ifdef FFT_IFFT_EN
      input  i_inverse,
`endif
      output o_busy, o_done, o_stage, o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_addr,
             o_wr_en, o_wr_addr_a, o_wr_addr_b, o_tw_conj
   );

   modport slave (
      output i_start,
`ifdef FFT_IFFT_EN
      output i_inverse,
`endif
      input  o_busy, o_done, o_stage, o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_addr,
             o_wr_en, o_wr_addr_a, o_wr_addr_b, o_tw_conj
   );
endinterface

// File: rtl/fft_bf_sequencer.sv
// In-place radix-2 DIT FFT control: issues one butterfly pair per cycle, drives twiddle and
// delayed write-back addresses. Macro FFT_IFFT_EN enables the inverse (conjugate twiddle) input.
module fft_bf_sequencer #(
   parameter int LOG2N  = 3,
   parameter int BF_LAT = 2
) (
   input logic                 i_clk,
   input logic                 i_rst,
   fft_bf_sequencer_if.master  bus
);
   localparam int JW = LOG2N - 1;
   localparam int CW = $clog2(BF_LAT + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t           r_state;
   logic [JW-1:0]    r_j;
   logic [LOG2N-1:0] r_s;
   logic [CW-1:0]    r_cnt;
   logic             r_busy, r_done, r_rd_en;
   logic [LOG2N-1:0] r_rd_a, r_rd_b;
   logic [JW-1:0]    r_tw;

   logic [BF_LAT:1]             r_vld_pipe;
   logic [BF_LAT:1][LOG2N-1:0]  r_wa_pipe, r_wb_pipe;

   logic [JW-1:0]    w_jn;
   logic [LOG2N-1:0] w_na, w_nb;
   logic [JW-1:0]    w_ntw;

   function automatic logic [LOG2N-1:0] f_rotl(input logic [LOG2N-1:0] x,
                                               input logic [LOG2N-1:0] s);
      logic [2*LOG2N-1:0] w;
      w = {x, x} << s;
      return w[2*LOG2N-1:LOG2N];
   endfunction

   // Stage s keeps only the top s bits of j as twiddle index.
   function automatic logic [JW-1:0] f_mask(input logic [LOG2N-1:0] s);
      logic [LOG2N-1:0] lo;
      lo = (LOG2N'(1) << (LOG2N - 1 - s)) - LOG2N'(1);
      return ~lo[JW-1:0];
   endfunction

   assign w_jn  = r_j + 1'b1;
   assign w_na  = f_rotl({w_jn, 1'b0}, r_s);
   assign w_nb  = f_rotl({w_jn, 1'b1}, r_s);
   assign w_ntw = w_jn & f_mask(r_s);

`ifdef FFT_IFFT_EN
   logic r_inv, r_conj;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_j     <= '0;
         r_s     <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_rd_en <= 1'b0;
         r_rd_a  <= '0;
         r_rd_b  <= '0;
         r_tw    <= '0;
`ifdef FFT_IFFT_EN
         r_inv   <= 1'b0;
         r_conj  <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (bus.i_start) begin
                  r_state <= S_RUN;
                  r_busy  <= 1'b1;
                  r_j     <= '0;
                  r_s     <= '0;
                  r_rd_en <= 1'b1;
                  r_rd_a  <= '0;
                  r_rd_b  <= LOG2N'(1);
                  r_tw    <= '0;
`ifdef FFT_IFFT_EN
                  r_inv   <= bus.i_inverse;
                  r_conj  <= bus.i_inverse;
`endif
               end else begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_s     <= '0;
               end
            end
            S_RUN: begin
               if (&r_j) begin
                  r_state <= S_DRAIN;
                  r_cnt   <= CW'(BF_LAT);
                  r_rd_en <= 1'b0;
                  r_rd_a  <= '0;
                  r_rd_b  <= '0;
                  r_tw    <= '0;
`ifdef FFT_IFFT_EN
                  r_conj  <= 1'b0;
`endif
               end else begin
                  r_j    <= w_jn;
                  r_rd_a <= w_na;
                  r_rd_b <= w_nb;
                  r_tw   <= w_ntw;
               end
            end
            S_DRAIN: begin
               if (r_cnt == CW'(1)) begin
                  if (r_s == LOG2N'(LOG2N - 1)) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     // First pair of every stage is (0, 1<<s) with twiddle 0.
                     r_state <= S_RUN;
                     r_s     <= r_s + 1'b1;
                     r_j     <= '0;
                     r_rd_en <= 1'b1;
                     r_rd_a  <= '0;
                     r_rd_b  <= LOG2N'(1) << (r_s + 1'b1);
                     r_tw    <= '0;
`ifdef FFT_IFFT_EN
                     r_conj  <= r_inv;
`endif
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Write-back follows the reads by exactly BF_LAT cycles.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_vld_pipe <= '0;
         r_wa_pipe  <= '0;
         r_wb_pipe  <= '0;
      end else begin
         r_vld_pipe[1] <= r_rd_en;
         r_wa_pipe[1]  <= r_rd_a;
         r_wb_pipe[1]  <= r_rd_b;
         for (int k = 2; k <= BF_LAT; k++) begin
            r_vld_pipe[k] <= r_vld_pipe[k-1];
            r_wa_pipe[k]  <= r_wa_pipe[k-1];
            r_wb_pipe[k]  <= r_wb_pipe[k-1];
         end
      end
   end

   assign bus.o_busy      = r_busy;
   assign bus.o_done      = r_done;
   assign bus.o_stage     = r_s;
   assign bus.o_rd_en     = r_rd_en;
   assign bus.o_rd_addr_a = r_rd_a;
   assign bus.o_rd_addr_b = r_rd_b;
   assign bus.o_tw_addr   = r_tw;
   assign bus.o_wr_en     = r_vld_pipe[BF_LAT];
   assign bus.o_wr_addr_a = r_wa_pipe[BF_LAT];
   assign bus.o_wr_addr_b = r_wb_pipe[BF_LAT];
`ifdef FFT_IFFT_EN
   assign bus.o_tw_conj   = r_conj;
`else
   assign bus.o_tw_conj   = 1'b0;
`endif
endmodule

// File: tb/tb_fft_bf_sequencer.sv
// Scoreboard bench: stimulus pushes hand-computed pairs/writes/done times, monitors pop and compare.
module tb_fft_bf_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst2 = 1'b1;
   int   cyc = 0;
   int   n_chk = 0, n_fail = 0;
   int   wr_cnt = 0, rd2_cnt = 0, wr2_cnt = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fft_bf_sequencer_if #(.LOG2N(3)) bus ();
   fft_bf_sequencer_if #(.LOG2N(5)) bus2 ();

   fft_bf_sequencer #(.LOG2N(3), .BF_LAT(2)) dut  (.i_clk(clk), .i_rst(rst),  .bus(bus));
   fft_bf_sequencer #(.LOG2N(5), .BF_LAT(4)) dut2 (.i_clk(clk), .i_rst(rst2), .bus(bus2));

   typedef struct { int cyc; logic [31:0] v; } exp_t;
   exp_t exp_rd[$], exp_wr[$];
   int   exp_done[$], exp_done2[$];

   // Hand-computed N=8 pair tables: stages 0,1,2 x j=0..3
   localparam int TA[12]  = '{0,2,4,6, 0,4,1,5, 0,1,2,3};
   localparam int TB[12]  = '{1,3,5,7, 2,6,3,7, 4,5,6,7};
   localparam int TTW[12] = '{0,0,0,0, 0,0,2,2, 0,1,2,3};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [31:0] rd_pack(input int s, input int a, input int b, input int tw,
                                           input logic cj);
      logic [2:0] s3, a3, b3;
      logic [1:0] t2;
      s3 = 3'(s); a3 = 3'(a); b3 = 3'(b); t2 = 2'(tw);
      return {20'd0, s3, a3, b3, t2, cj};
   endfunction

   function automatic logic [31:0] all_outs();
      return {bus.o_busy, bus.o_done, bus.o_stage, bus.o_rd_en, bus.o_rd_addr_a, bus.o_rd_addr_b,
              bus.o_tw_addr, bus.o_wr_en, bus.o_wr_addr_a, bus.o_wr_addr_b, bus.o_tw_conj};
   endfunction

   task automatic push_run(input int t0, input logic inv);
      logic cj;
`ifdef FFT_IFFT_EN
      cj = inv;
`else
      cj = 1'b0;
`endif
      for (int s = 0; s < 3; s++)
         for (int j = 0; j < 4; j++) begin
            int k, c;
            exp_t e;
            k = s*4 + j;
            c = t0 + 1 + s*6 + j;
            e.cyc = c;     e.v = rd_pack(s, TA[k], TB[k], TTW[k], cj); exp_rd.push_back(e);
            e.cyc = c + 2; e.v = {26'd0, 3'(TA[k]), 3'(TB[k])};        exp_wr.push_back(e);
         end
      exp_done.push_back(t0 + 19);
   endtask

   task automatic drive_start(input logic st, input logic inv);
      bus.i_start = st;
`ifdef FFT_IFFT_EN
      bus.i_inverse = inv;
`else
      if (inv) bus.i_start = st;
`endif
   endtask

   // Monitor for the N=8 instance
   always @(negedge clk) begin
      if (bus.o_rd_en) begin
         if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
         else begin
            exp_t e;
            e = exp_rd.pop_front();
            chk("rd_cycle", cyc, e.cyc);
            chk("rd_fields", rd_pack(int'(bus.o_stage), int'(bus.o_rd_addr_a), int'(bus.o_rd_addr_b),
                                     int'(bus.o_tw_addr), bus.o_tw_conj), e.v);
            chk("rd_busy", bus.o_busy, 1);
         end
      end else begin
         chk("conj_idle", bus.o_tw_conj, 0);
      end
      if (bus.o_wr_en) begin
         wr_cnt++;
         if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
         else begin
            exp_t e;
            e = exp_wr.pop_front();
            chk("wr_cycle", cyc, e.cyc);
            chk("wr_addr", {26'd0, bus.o_wr_addr_a, bus.o_wr_addr_b}, e.v);
         end
      end
      if (bus.o_done) begin
         if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
         else begin
            chk("done_cycle", cyc, exp_done.pop_front());
            chk("done_busy_stage", {bus.o_busy, bus.o_stage}, {1'b1, 3'd2});
         end
      end
   end

   // Monitor for the N=32, BF_LAT=4 instance
   always @(negedge clk) begin
      if (bus2.o_rd_en) rd2_cnt++;
      if (bus2.o_wr_en) wr2_cnt++;
      if (bus2.o_done) begin
         if (exp_done2.size() == 0) chk("done2_unexpected", 1, 0);
         else chk("done2_cycle", cyc, exp_done2.pop_front());
      end
   end

   initial begin
      int t0, rel;
      drive_start(1'b0, 1'b0);
      bus2.i_start = 1'b0;
`ifdef FFT_IFFT_EN
      bus2.i_inverse = 1'b0;
`endif
      repeat (3) @(negedge clk);
      chk("reset_outs", all_outs(), 0);
      rst = 1'b0; rst2 = 1'b0;
      repeat (2) @(negedge clk);

      // Plain run (inverse=1 where supported) plus the large instance in parallel
      t0 = cyc;
      wr_cnt = 0;
      drive_start(1'b1, 1'b1);
      bus2.i_start = 1'b1;
      push_run(t0, 1'b1);
      exp_done2.push_back(t0 + 101);
      @(negedge clk);
      drive_start(1'b0, 1'b0);
      bus2.i_start = 1'b0;
      while (cyc < t0 + 20) @(negedge clk);
      chk("idle_busy_stage", {bus.o_busy, bus.o_stage}, 0);
      chk("wr_pulses_12", wr_cnt, 12);

      // Starts during RUN are ignored; start held in DONE chains a new run
      @(negedge clk);
      t0 = cyc;
      push_run(t0, 1'b0);
      for (rel = 0; rel < 40; rel++) begin
         drive_start(rel == 0 || rel == 3 || rel == 10 || rel == 19, 1'b0);
         if (rel == 19) push_run(t0 + 19, 1'b0);
         if (rel == 20) chk("back_to_back_busy", bus.o_busy, 1);
         @(negedge clk);
      end
      drive_start(1'b0, 1'b0);
      chk("idle_after_chain", bus.o_busy, 0);

      // Reset at cycle 8 of a run, then a full clean run
      t0 = cyc;
      drive_start(1'b1, 1'b0);
      push_run(t0, 1'b0);
      @(negedge clk);
      drive_start(1'b0, 1'b0);
      while (cyc < t0 + 8) @(negedge clk);
      #2 rst = 1'b1;
      #1 chk("async_reset", all_outs(), 0);
      exp_rd.delete(); exp_wr.delete(); exp_done.delete();
      repeat (3) @(negedge clk);
      chk("reset_hold_wr", bus.o_wr_en, 0);
      rst = 1'b0;
      @(negedge clk);
      t0 = cyc;
      drive_start(1'b1, 1'b0);
      push_run(t0, 1'b0);
      @(negedge clk);
      drive_start(1'b0, 1'b0);
      while (cyc < t0 + 21) @(negedge clk);

      for (int i = 0; i < 200 && exp_done2.size() != 0; i++) @(negedge clk);
      chk("rd_q_empty", exp_rd.size(), 0);
      chk("wr_q_empty", exp_wr.size(), 0);
      chk("done_q_empty", exp_done.size(), 0);
      chk("done2_q_empty", exp_done2.size(), 0);
      chk("rd2_pairs_80", rd2_cnt, 80);
      chk("wr2_pairs_80", wr2_cnt, 80);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
